// File: rtl/riio_pwr_seq.sv
// riio_pwr_seq: sequences NCH IO supply switches on in ascending order, each
// gated by a qualified power-good, and off in descending order with a fixed
// settle wait. Loss of power-good or a stuck channel latches a fault.
// Optional feature macro: RIIO_PWR_SEQ_DEBOUNCE_EN
//   defined   : a channel qualifies after DEB_CYC consecutive high pg_s cycles
//   undefined : a channel qualifies on the first high pg_s cycle (no counter)
// The power-down settle wait always lasts DEB_CYC cycles per channel.
module riio_pwr_seq #(
  parameter int NCH     = 4,
  parameter int DEB_CYC = 8,
  parameter int TIMEOUT = 255,
  parameter int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_on_i,
  input  logic [NCH-1:0] pg_i,
  input  logic           clr_fault_i,
  output logic [NCH-1:0] en_o,
  output logic           busy_o,
  output logic           on_o,
  output logic           fault_o,
  output logic [CW-1:0]  fault_ch_o
);

  typedef enum logic [2:0] {S_OFF, S_UP, S_ON, S_DOWN, S_FAULT} state_t;

  localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
  localparam logic [7:0]    WAIT_LAST = 8'(DEB_CYC - 1);
  localparam logic [15:0]   TMO_V     = 16'(TIMEOUT);

  state_t         state, state_nxt;
  logic [CW-1:0]  ch, ch_nxt;
  logic [CW-1:0]  fault_ch_nxt;
  logic [CW-1:0]  low_idx;
  logic [NCH-1:0] pg_meta, pg_s;
  logic [15:0]    tmr, tmr_nxt;
  logic [7:0]     wcnt, wcnt_nxt;
  logic           qualified;
  logic [NCH-1:0] en_nxt;
  logic           busy_nxt, on_nxt, fault_nxt;

`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
  localparam logic [7:0] DEB_V = 8'(DEB_CYC);
  logic [7:0] qcnt, qcnt_nxt;
  assign qualified = (qcnt == DEB_V);
`else
  assign qualified = pg_s[ch];
`endif

  // Lowest-index channel whose synchronised power-good is low.
  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!pg_s[i]) low_idx = CW'(i);
    end
  end

  // Next-state logic: sequencing decisions plus counter and channel updates.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_nxt    = state;
    ch_nxt       = ch;
    fault_ch_nxt = fault_ch_o;
    tmr_nxt      = (tmr == 16'hFFFF) ? tmr : tmr + 16'd1;
    wcnt_nxt     = '0;
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
    qcnt_nxt     = '0;
`endif
    unique case (state)
      S_OFF: begin
        if (req_on_i) begin
          state_nxt = S_UP;
          ch_nxt    = '0;
          tmr_nxt   = '0;
        end
      end
      S_UP: begin
        if (!req_on_i) begin
          // Pending channel is already switched on; shed it first.
          state_nxt = S_DOWN;
        end else if (qualified) begin
          // Qualification beats a timeout reached in the same cycle.
          if (ch == LAST_CH) begin
            state_nxt = S_ON;
          end else begin
            ch_nxt  = ch + 1'b1;
            tmr_nxt = '0;
          end
        end else if (tmr == TMO_V) begin
          state_nxt    = S_FAULT;
          fault_ch_nxt = ch;
        end else begin
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
          if (pg_s[ch]) qcnt_nxt = (qcnt == 8'hFF) ? qcnt : qcnt + 8'd1;
`endif
        end
      end
      S_ON: begin
        // Supply loss outranks a power-down request.
        if (pg_s != '1) begin
          state_nxt    = S_FAULT;
          fault_ch_nxt = low_idx;
        end else if (!req_on_i) begin
          state_nxt = S_DOWN;
          ch_nxt    = LAST_CH;
        end
      end
      S_DOWN: begin
        if (wcnt == WAIT_LAST) begin
          if (ch == '0) state_nxt = S_OFF;
          else          ch_nxt    = ch - 1'b1;
        end else begin
          wcnt_nxt = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
        end
      end
      S_FAULT: begin
        if (clr_fault_i && !req_on_i) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_nxt  = (state_nxt == S_UP) || (state_nxt == S_DOWN);
    on_nxt    = (state_nxt == S_ON);
    fault_nxt = (state_nxt == S_FAULT);
    en_nxt    = '0;
    for (int i = 0; i < NCH; i++) begin
      unique case (state_nxt)
        S_UP:    en_nxt[i] = (i <= int'(ch_nxt));
        S_ON:    en_nxt[i] = 1'b1;
        S_DOWN:  en_nxt[i] = (i < int'(ch_nxt));
        default: en_nxt[i] = 1'b0;
      endcase
    end
  end

  // State, counters, synchroniser and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= S_OFF;
      ch         <= '0;
      pg_meta    <= '0;
      pg_s       <= '0;
      tmr        <= '0;
      wcnt       <= '0;
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
      qcnt       <= '0;
`endif
      en_o       <= '0;
      busy_o     <= 1'b0;
      on_o       <= 1'b0;
      fault_o    <= 1'b0;
      fault_ch_o <= '0;
    end else begin
      state      <= state_nxt;
      ch         <= ch_nxt;
      pg_meta    <= pg_i;
      pg_s       <= pg_meta;
      tmr        <= tmr_nxt;
      wcnt       <= wcnt_nxt;
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
      qcnt       <= qcnt_nxt;
`endif
      en_o       <= en_nxt;
      busy_o     <= busy_nxt;
      on_o       <= on_nxt;
      fault_o    <= fault_nxt;
      fault_ch_o <= fault_ch_nxt;
    end
  end

endmodule

// File: tb/tb_riio_pwr_seq.sv
// tb_riio_pwr_seq: directed scenarios with literal timing expectations plus a
// randomized run, all compared every cycle against a behavioural model that
// tracks "how many supplies are on" rather than channel indices.
module tb_riio_pwr_seq;

  localparam int NCH = 4;
  localparam int DEB = 8;
  localparam int TMO = 255;
  localparam int CW  = 2;
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
  localparam int QUAL_LAT = 2 + DEB;
`else
  localparam int QUAL_LAT = 2;
`endif
  localparam int SEL_ON    = 4;
  localparam int SEL_FAULT = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_on = 1'b0;
  logic           clr_fault = 1'b0;
  logic [NCH-1:0] pg = '0;
  logic [NCH-1:0] en;
  logic           busy, on, fault;
  logic [CW-1:0]  fault_ch;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  riio_pwr_seq #(.NCH(NCH), .DEB_CYC(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_on_i(req_on), .pg_i(pg),
    .clr_fault_i(clr_fault), .en_o(en), .busy_o(busy), .on_o(on),
    .fault_o(fault), .fault_ch_o(fault_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_RAMP = 1, P_ALL = 2, P_SHED = 3, P_TRIP = 4;
  int             m_phase = P_IDLE;
  int             m_k = 0;       // number of supplies switched on
  int             m_run = 0;     // consecutive synchronised-high cycles of newest supply
  int             m_age = 0;     // cycles since newest supply was switched on
  int             m_hold = 0;    // cycles spent settling during shedding
  int             m_trip = 0;
  logic [NCH-1:0] m_s1 = '0, m_s2 = '0;

  task automatic model_step();
    logic [NCH-1:0] s_now;
    bit             qual;
    s_now = m_s2;
    if (!rst_n) begin
      m_phase = P_IDLE; m_k = 0; m_run = 0; m_age = 0; m_hold = 0; m_trip = 0;
      m_s1 = '0; m_s2 = '0;
      return;
    end
    case (m_phase)
      P_IDLE: if (req_on) begin m_phase = P_RAMP; m_k = 1; m_run = 0; m_age = 0; end
      P_RAMP: begin
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
        qual = (m_run >= DEB);
`else
        qual = s_now[m_k-1];
`endif
        if (!req_on) begin
          m_phase = P_SHED; m_k = m_k - 1; m_hold = 0;
        end else if (qual) begin
          if (m_k == NCH) m_phase = P_ALL;
          else begin m_k++; m_run = 0; m_age = 0; end
        end else if (m_age == TMO) begin
          m_phase = P_TRIP; m_trip = m_k - 1; m_k = 0;
        end else begin
          m_run = s_now[m_k-1] ? ((m_run < 255) ? m_run + 1 : 255) : 0;
          m_age = (m_age < 65535) ? m_age + 1 : 65535;
        end
      end
      P_ALL: begin
        if (s_now != '1) begin
          m_phase = P_TRIP; m_k = 0;
          for (int i = NCH - 1; i >= 0; i--) if (!s_now[i]) m_trip = i;
        end else if (!req_on) begin
          m_phase = P_SHED; m_k = NCH - 1; m_hold = 0;
        end
      end
      P_SHED: begin
        if (m_hold == DEB - 1) begin
          if (m_k == 0) m_phase = P_IDLE;
          else begin m_k--; m_hold = 0; end
        end else m_hold++;
      end
      P_TRIP: if (clr_fault && !req_on) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    m_s2 = m_s1;
    m_s1 = pg;
  endtask

  // Per-cycle compare of every output against the model, plus invariants.
  always @(posedge clk) begin
    logic [NCH-1:0] exp_en, en_p1;
    model_step();
    cyc++;
    #1;
    exp_en = NCH'((1 << m_k) - 1);
    check("en", en, exp_en);
    check("busy", busy, (m_phase == P_RAMP) || (m_phase == P_SHED));
    check("on", on, m_phase == P_ALL);
    check("fault", fault, m_phase == P_TRIP);
    check("fault_ch", fault_ch, m_trip);
    en_p1 = en + 1'b1;
    check("en_thermometer", (en & en_p1) == '0, 1'b1);
    check("flags_exclusive", (int'(busy) + int'(on) + int'(fault)) <= 1, 1'b1);
  end

  // ---------------- directed helpers ----------------
  function automatic logic sel_val(input int sel);
    if (sel < NCH)          return en[sel];
    else if (sel == SEL_ON) return on;
    else                    return fault;
  endfunction

  task automatic wait_for(input int sel, input string name, output int edge_no);
    edge_no = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (sel_val(sel)) begin edge_no = cyc; return; end
    end
    check(name, sel_val(sel), 1'b1);
  endtask

  // Nominal ramp: each pg goes high 5 cycles after its enable.
  task automatic nominal_up();
    int e, p, e2;
    pg = '0;
    @(negedge clk);
    req_on = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      wait_for(k, $sformatf("wait_en%0d", k), e);
      repeat (5) @(negedge clk);
      pg[k] = 1'b1;
      p = cyc;
      if (k < NCH - 1) wait_for(k + 1, $sformatf("wait_en%0d", k + 1), e2);
      else             wait_for(SEL_ON, "wait_on", e2);
      check($sformatf("up_step%0d_latency", k), e2 - (p + 1), QUAL_LAT);
    end
  endtask

  initial begin
    int e, p, a, f, p0, p2;
    int steps[$];
    logic [NCH-1:0] vals[$];
    logic [NCH-1:0] prev;
    int quality;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", en, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_on", on, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_fault_ch", fault_ch, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal power-up
    nominal_up();
    check("nom_on", on, 1'b1);
    check("nom_en", en, 4'b1111);
    check("nom_fault", fault, 1'b0);

    // Power-down: 0111, 0011, 0001, 0000, 8 cycles apart, then OFF
    req_on = 1'b0;
    p = cyc;
    prev = en;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (en != prev) begin steps.push_back(cyc); vals.push_back(en); prev = en; end
    end
    check("dn_nsteps", steps.size(), 4);
    if (steps.size() == 4) begin
      check("dn_first_edge", steps[0], p + 1);
      check("dn_v0", vals[0], 4'b0111);
      check("dn_v1", vals[1], 4'b0011);
      check("dn_v2", vals[2], 4'b0001);
      check("dn_v3", vals[3], 4'b0000);
      for (int i = 1; i < 4; i++) check($sformatf("dn_gap%0d", i), steps[i] - steps[i-1], 8);
    end
    check("dn_busy", busy, 1'b0);
    check("dn_on", on, 1'b0);

    // Loss in ON, then fault clear rules
    nominal_up();
    pg[3] = 1'b0;
    p = cyc;
    wait_for(SEL_FAULT, "wait_loss_fault", f);
    check("loss_latency", f - (p + 1), 2);
    check("loss_fault_ch", fault_ch, 2'd3);
    check("loss_en", en, 4'b0000);
    clr_fault = 1'b1;
    repeat (5) @(negedge clk);
    check("clr_with_req_stays", fault, 1'b1);
    req_on = 1'b0;
    @(negedge clk);
    check("clr_exit_fault", fault, 1'b0);
    check("clr_exit_busy", busy, 1'b0);
    clr_fault = 1'b0;
    @(negedge clk);

    // Timeout on channel 2
    pg = '0;
    req_on = 1'b1;
    @(negedge clk);
    pg = 4'b0011;
    wait_for(2, "wait_tmo_en2", a);
    wait_for(SEL_FAULT, "wait_tmo_fault", f);
    check("tmo_latency", f - a, TMO + 1);
    check("tmo_fault_ch", fault_ch, 2'd2);
    check("tmo_en", en, 4'b0000);
    req_on = 1'b0;
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    @(negedge clk);

    // Glitch on channel 1 restarts qualification; then reset mid-ramp
    pg = '0;
    req_on = 1'b1;
    wait_for(0, "wait_gl_en0", e);
    pg[0] = 1'b1;
    wait_for(1, "wait_gl_en1", e);
    repeat (5) @(negedge clk);
    pg[1] = 1'b1;
    p0 = cyc;
`ifdef RIIO_PWR_SEQ_DEBOUNCE_EN
    repeat (5) @(negedge clk);
    pg[1] = 1'b0;
    @(negedge clk);
    pg[1] = 1'b1;
    p2 = cyc;
    wait_for(2, "wait_gl_en2", e);
    check("glitch_restart", e - (p2 + 1), QUAL_LAT);
`else
    p2 = p0;
    wait_for(2, "wait_gl_en2", e);
    check("noglitch_first_high", e - (p2 + 1), QUAL_LAT);
`endif
    check("mid_up_en", en, 4'b0111);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_up_reset_en", en, 4'b0000);
    check("mid_up_reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    req_on = 1'b0;
    pg = '0;
    @(negedge clk);

    // Randomized run against the model
    quality = 100;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (n % 250 == 0) quality = $urandom_range(88, 100);
      for (int i = 0; i < NCH; i++) pg[i] = ($urandom_range(0, 99) < quality);
      if ($urandom_range(0, 59) == 0) req_on = ~req_on;
      clr_fault = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
